clock_divider_bank: RTL and testbench



---
 rtl/clock_divider_bank.sv | 110 +++++++++++
 tb/tb_clock_divider_bank.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_bank.sv
// clock_divider_bank: multi-channel programmable clock divider and tick generator.
// Each channel counts 0..div and then wraps. The wrap edge raises a one-cycle
// tick and toggles a 50%-duty divided clock, so the period is 2*(div+1) cycles.
// A new divisor never cuts a period short. A running channel holds it as
// pending until its next terminal edge. A disabled channel, or any channel
// on a sync edge, takes it at once.

module clock_divider_bank #(
    parameter int          CHANNELS    = 4,
    parameter int          WIDTH       = 26,
    parameter int unsigned DEFAULT_DIV = 500000,
    parameter int          SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       enable,
    input  logic                      sync,
    input  logic                      load,
    input  logic [SEL_W-1:0]          load_sel,
    input  logic [WIDTH-1:0]          load_value,
    output logic                      load_ack,
    output logic [CHANNELS-1:0]       divided_clock,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS*WIDTH-1:0] clock_count
);

    // One extra bit so that the channel count itself is representable when
    // it is an exact power of two.
    localparam logic [SEL_W:0]   CH_LIMIT  = (SEL_W + 1)'(CHANNELS);
    localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);

    logic load_accept;

    // A select value at or beyond the channel count is silently dropped.
    assign load_accept = load && ({1'b0, load_sel} < CH_LIMIT);

    // Acknowledge register: one pulse for every accepted load.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            load_ack <= 1'b0;
        end else begin
            load_ack <= load_accept;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] count;
        logic [WIDTH-1:0] div;
        logic [WIDTH-1:0] pend;
        logic             pend_valid;
        logic             dclk_q;
        logic             tick_q;
        logic             load_hit;
        logic             terminal;
        logic [WIDTH-1:0] next_div;

        assign load_hit = load_accept && (load_sel == SEL_W'(i));

        // Treated as terminal also when count is above div. A disabled
        // channel can take a divisor smaller than its held count, and this
        // lets it wrap cleanly instead of running through the whole range.
        assign terminal = (count >= div);

        // Divisor to install at a safe point. A same-edge load beats an older
        // pending value, and a pending value beats the current divisor.
        assign next_div = load_hit ? load_value : (pend_valid ? pend : div);

        // Per-channel counter, divisor staging and output registers.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                count      <= '0;
                div        <= RESET_DIV;
                pend       <= '0;
                pend_valid <= 1'b0;
                dclk_q     <= 1'b0;
                tick_q     <= 1'b0;
            end else if (sync) begin
                count      <= '0;
                dclk_q     <= 1'b0;
                tick_q     <= 1'b0;
                div        <= next_div;
                pend_valid <= 1'b0;
            end else if (!enable[i]) begin
                tick_q     <= 1'b0;
                div        <= next_div;
                pend_valid <= 1'b0;
            end else if (terminal) begin
                count      <= '0;
                tick_q     <= 1'b1;
                dclk_q     <= ~dclk_q;
                div        <= next_div;
                pend_valid <= 1'b0;
            end else begin
                count  <= count + WIDTH'(1);
                tick_q <= 1'b0;
                if (load_hit) begin
                    pend       <= load_value;
                    pend_valid <= 1'b1;
                end
            end
        end

        assign divided_clock[i]              = dclk_q;
        assign tick[i]                       = tick_q;
        assign clock_count[i*WIDTH +: WIDTH] = count;
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed testbench for clock_divider_bank. The instance is four channels of
// eight bits with a small reset divisor. load_sel is one bit wider than it
// needs to be, so that select values beyond the channel count can be driven.

module tb_clock_divider_bank;

    localparam int CHANNELS    = 4;
    localparam int WIDTH       = 8;
    localparam int DEFAULT_DIV = 9;
    localparam int SEL_W       = 3;

    logic                      clock;
    logic                      reset_n;
    logic [CHANNELS-1:0]       enable;
    logic                      sync;
    logic                      load;
    logic [SEL_W-1:0]          load_sel;
    logic [WIDTH-1:0]          load_value;
    logic                      load_ack;
    logic [CHANNELS-1:0]       divided_clock;
    logic [CHANNELS-1:0]       tick;
    logic [CHANNELS*WIDTH-1:0] clock_count;

    int pass_count  = 0;
    int check_count = 0;

    clock_divider_bank #(
        .CHANNELS   (CHANNELS),
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(DEFAULT_DIV),
        .SEL_W      (SEL_W)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .sync         (sync),
        .load         (load),
        .load_sel     (load_sel),
        .load_value   (load_value),
        .load_ack     (load_ack),
        .divided_clock(divided_clock),
        .tick         (tick),
        .clock_count  (clock_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge, then settle 1 ns so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    function automatic logic [31:0] cnt(input int ch);
        return 32'(clock_count[ch*WIDTH +: WIDTH]);
    endfunction

    function automatic logic [31:0] tk(input int ch);
        return 32'(tick[ch]);
    endfunction

    function automatic logic [31:0] dc(input int ch);
        return 32'(divided_clock[ch]);
    endfunction

    task automatic do_load(input int ch, input int value);
        load       = 1'b1;
        load_sel   = SEL_W'(ch);
        load_value = WIDTH'(value);
    endtask

    // Expected values for the ch1 divisor change from 5 to 2 (edges 4..12).
    int t2_count [9] = '{4, 5, 0, 1, 2, 0, 1, 2, 0};
    int t2_tick  [9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
    // Expected tick vectors after the sync edge, for D = 1, 2, 3, 4 on ch0..ch3 (edges 1..6).
    int t4_tick  [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0101, 4'b1000, 4'b0011};

    initial begin
        reset_n    = 1'b0;
        enable     = '0;
        sync       = 1'b0;
        load       = 1'b0;
        load_sel   = '0;
        load_value = '0;

        // ---- reset state ----
        #3;
        check("reset_tick", 32'(tick), 32'h0);
        check("reset_dclk", 32'(divided_clock), 32'h0);
        check("reset_ack", 32'(load_ack), 32'h0);
        check("reset_count", 32'(clock_count), 32'h0);
        step();
        reset_n = 1'b1;

        // ---- ch0: D=3 loaded while disabled, then run ----
        do_load(0, 3);
        step();
        check("t1_ack_pulse", 32'(load_ack), 32'h1);
        check("t1_count_held", cnt(0), 32'h0);
        load = 1'b0;
        step();
        check("t1_ack_clear", 32'(load_ack), 32'h0);
        enable = 4'b0001;
        for (int e = 1; e <= 12; e++) begin
            step();
            check($sformatf("t1_tick_e%0d", e), tk(0), 32'((e % 4) == 0));
            check($sformatf("t1_dclk_e%0d", e), dc(0), 32'(((e / 4) % 2) == 1));
            check($sformatf("t1_count_e%0d", e), cnt(0), 32'(e % 4));
        end
        enable = 4'b0000;

        // ---- ch1: D=5, change to D=2 at count 2 ----
        do_load(1, 5);
        step();
        load   = 1'b0;
        enable = 4'b0010;
        step();
        step();
        check("t2_count_e2", cnt(1), 32'h2);
        do_load(1, 2);
        step();
        check("t2_count_e3", cnt(1), 32'h3);
        check("t2_ack", 32'(load_ack), 32'h1);
        load = 1'b0;
        for (int k = 0; k < 9; k++) begin
            step();
            check($sformatf("t2_count_e%0d", k + 4), cnt(1), 32'(t2_count[k]));
            check($sformatf("t2_tick_e%0d", k + 4), tk(1), 32'(t2_tick[k]));
            check($sformatf("t2_count_max_e%0d", k + 4), 32'(cnt(1) <= 5), 32'h1);
        end
        enable = 4'b0000;

        // ---- ch2: two loads before terminal, last wins ----
        enable = 4'b0100;
        step();
        do_load(2, 7);
        step();
        check("t3_ack1", 32'(load_ack), 32'h1);
        load = 1'b0;
        step();
        check("t3_ack1_clear", 32'(load_ack), 32'h0);
        do_load(2, 1);
        step();
        check("t3_ack2", 32'(load_ack), 32'h1);
        load = 1'b0;
        step();
        check("t3_ack2_clear", 32'(load_ack), 32'h0);
        step();
        step();
        step();
        check("t3_tick_e8", tk(2), 32'h0);
        check("t3_count_e8", cnt(2), 32'h8);
        step();
        check("t3_count_e9", cnt(2), 32'h9);
        step();
        check("t3_tick_e10", tk(2), 32'h1);
        check("t3_count_e10", cnt(2), 32'h0);
        step();
        check("t3_tick_e11", tk(2), 32'h0);
        step();
        check("t3_tick_e12", tk(2), 32'h1);
        step();
        check("t3_tick_e13", tk(2), 32'h0);
        step();
        check("t3_tick_e14", tk(2), 32'h1);
        enable = 4'b0000;

        // ---- all channels D=1..4 free-running, then sync ----
        for (int ch = 0; ch < CHANNELS; ch++) begin
            do_load(ch, ch + 1);
            step();
        end
        load   = 1'b0;
        enable = 4'b1111;
        repeat (7) step();
        sync = 1'b1;
        step();
        check("t4_sync_dclk", 32'(divided_clock), 32'h0);
        check("t4_sync_count", 32'(clock_count), 32'h0);
        check("t4_sync_tick", 32'(tick), 32'h0);
        sync = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            step();
            check($sformatf("t4_tick_e%0d", e), 32'(tick), 32'(t4_tick[e-1]));
            if (e == 5) check("t4_dclk_e5", 32'(divided_clock), 32'b1110);
        end

        // ---- ch3: D=0 applied by a same-edge load on sync ----
        sync = 1'b1;
        do_load(3, 0);
        step();
        check("t5_ack", 32'(load_ack), 32'h1);
        check("t5_tick3_sync", tk(3), 32'h0);
        sync = 1'b0;
        load = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            step();
            check($sformatf("t5_tick3_e%0d", e), tk(3), 32'h1);
            check($sformatf("t5_dclk3_e%0d", e), dc(3), 32'(e % 2));
            check($sformatf("t5_count3_e%0d", e), cnt(3), 32'h0);
        end
        // out-of-range select: no ack, ch3 keeps D=0
        do_load(7, 5);
        step();
        check("t5_oor_ack", 32'(load_ack), 32'h0);
        check("t5_oor_tick3", tk(3), 32'h1);
        check("t5_oor_dclk3", dc(3), 32'h1);
        load = 1'b0;
        step();
        check("t5_oor_ack_after", 32'(load_ack), 32'h0);
        check("t5_oor_tick3_after", tk(3), 32'h1);
        check("t5_oor_dclk3_after", dc(3), 32'h0);

        // ---- asynchronous reset mid-count on a D=3 channel ----
        enable = 4'b1001;
        sync   = 1'b1;
        do_load(0, 3);
        step();
        check("t6_ack", 32'(load_ack), 32'h1);
        sync = 1'b0;
        load = 1'b0;
        step();
        do_load(1, 6);
        step();
        load = 1'b0;
        check("t6_pre_count0", cnt(0), 32'h2);
        check("t6_pre_ack", 32'(load_ack), 32'h1);
        check("t6_pre_tick3", tk(3), 32'h1);
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_rst_tick", 32'(tick), 32'h0);
        check("t6_rst_dclk", 32'(divided_clock), 32'h0);
        check("t6_rst_ack", 32'(load_ack), 32'h0);
        check("t6_rst_count", 32'(clock_count), 32'h0);
        reset_n = 1'b1;
        enable  = 4'b0001;
        for (int e = 1; e <= 10; e++) begin
            step();
            check($sformatf("t6_tick0_e%0d", e), tk(0), 32'(e == 10));
            check($sformatf("t6_count0_e%0d", e), cnt(0), 32'(e % 10));
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
